// File: rtl/sipo_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sipo_frame_ctrl_if
// Purpose  : Serial-in and parallel-out handshake bundle for sipo_frame_ctrl.
//            The master side drives the serial stream and accepts words.
//            The slave side is the deserialiser itself.
// Revision : 1.0  initial release
// ============================================================================
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             si;
    logic             si_vld;
    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic             q_rdy;

    modport master (
        output si,
        output si_vld,
        output q_rdy,
        input  q,
        input  q_vld
    );

    modport slave (
        input  si,
        input  si_vld,
        input  q_rdy,
        output q,
        output q_vld
    );
endinterface
`default_nettype wire

// File: rtl/sipo_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sipo_frame_ctrl
// Purpose  : Framed serial-to-parallel converter.
//            A frame is one start bit (si=1) followed by WIDTH data bits,
//            sent MSB first. The received word is presented on q with a
//            valid/ready handshake. A word that completes while the previous
//            word is still unconsumed is dropped and raises sticky ovr_err.
// Option   : Define SIPO_FRAME_PARITY_EN to add one even-parity bit after the
//            data bits. This also adds the sticky par_err output.
// Revision : 1.0  initial release
// ============================================================================
module sipo_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  wire              clk,
    input  wire              rst_n,
    sipo_frame_ctrl_if.slave bus,
    output logic             busy,
    output logic             ovr_err,
    input  wire              err_clr
`ifdef SIPO_FRAME_PARITY_EN
    ,
    output logic             par_err
`endif
);

    localparam int                 c_CNT_W    = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
`ifdef SIPO_FRAME_PARITY_EN
        S_PARITY = 2'd3,
`endif
        S_DONE   = 2'd2
    } state_t;

    state_t             r_state_q, w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,   w_cnt_d;
    logic [WIDTH-1:0]   r_shift_q, w_shift_d;
    logic [WIDTH-1:0]   r_q_q,     w_q_d;
    logic               r_q_vld_q, w_q_vld_d;
    logic               r_ovr_q,   w_ovr_d;
    logic               w_ovr_set;
`ifdef SIPO_FRAME_PARITY_EN
    logic               r_par_q,   w_par_d;
    logic               w_par_set;
`endif

    // Frame sequencing, shift register, output word register and error flags
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_shift_d = r_shift_q;
        w_q_d     = r_q_q;
        w_q_vld_d = r_q_vld_q;
        w_ovr_set = 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
        w_par_set = 1'b0;
`endif

        // The consumer taking the word frees the output register. A load in
        // DONE below overrides this default.
        if (r_q_vld_q && bus.q_rdy) begin
            w_q_vld_d = 1'b0;
        end

        case (r_state_q)
            S_IDLE: begin
                if (bus.si_vld && bus.si) begin
                    w_state_d = S_SHIFT;
                    w_cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                if (bus.si_vld) begin
                    w_shift_d = {r_shift_q[WIDTH-2:0], bus.si};
                    w_cnt_d   = r_cnt_q + 1'b1;
                    if (r_cnt_q == c_LAST_BIT) begin
`ifdef SIPO_FRAME_PARITY_EN
                        w_state_d = S_PARITY;
`else
                        w_state_d = S_DONE;
`endif
                    end
                end
            end
`ifdef SIPO_FRAME_PARITY_EN
            S_PARITY: begin
                if (bus.si_vld) begin
                    w_par_set = (^r_shift_q) ^ bus.si;
                    w_state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_state_d = S_IDLE;
                // A stalled consumer keeps the old word. The new word is lost.
                if (r_q_vld_q && !bus.q_rdy) begin
                    w_ovr_set = 1'b1;
                end else begin
                    w_q_d     = r_shift_q;
                    w_q_vld_d = 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        // When a set and a clear happen in the same cycle, the set wins.
        w_ovr_d = w_ovr_set ? 1'b1 : (err_clr ? 1'b0 : r_ovr_q);
`ifdef SIPO_FRAME_PARITY_EN
        w_par_d = w_par_set ? 1'b1 : (err_clr ? 1'b0 : r_par_q);
`endif
    end

    // State register with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= '0;
            r_shift_q <= '0;
            r_q_q     <= '0;
            r_q_vld_q <= 1'b0;
            r_ovr_q   <= 1'b0;
`ifdef SIPO_FRAME_PARITY_EN
            r_par_q   <= 1'b0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_shift_q <= w_shift_d;
            r_q_q     <= w_q_d;
            r_q_vld_q <= w_q_vld_d;
            r_ovr_q   <= w_ovr_d;
`ifdef SIPO_FRAME_PARITY_EN
            r_par_q   <= w_par_d;
`endif
        end
    end

    assign bus.q     = r_q_q;
    assign bus.q_vld = r_q_vld_q;
    assign busy      = (r_state_q != S_IDLE);
    assign ovr_err   = r_ovr_q;
`ifdef SIPO_FRAME_PARITY_EN
    assign par_err   = r_par_q;
`endif

endmodule
`default_nettype wire

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning the number of data bits per frame (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL provide port si  input  1  serial data bit, sampled only when si_vld=1.
REQ-005 SHALL provide port si_vld  input  1  qualifies si for the current cycle.
REQ-006 SHALL provide port q  output  WIDTH  parallel word held in the output register.
REQ-007 SHALL provide port q_vld  output  1  q holds an unconsumed word.
REQ-008 SHALL provide port q_rdy  input  1  consumer accepts q when q_vld=1 and q_rdy=1.
REQ-009 SHALL provide port busy  output  1  high in every state except IDLE.
REQ-010 SHALL provide port ovr_err  output  1  sticky overrun flag.
REQ-011 SHALL provide port err_clr  input  1  synchronous clear of the sticky error flags.

Function
REQ-012 SHALL implement FSM states IDLE, SHIFT and DONE, plus PARITY when PARITY_EN is defined.
REQ-013 IDLE: a qualified si=1 is the start bit -> SHIFT with bit counter=0; a qualified si=0 is ignored.
REQ-014 SHIFT: each qualified bit shifts into the internal shift register MSB-first (the first data bit ends at q[WIDTH-1]) and increments the counter; cycles with si_vld=0 hold all state.
REQ-015 After the WIDTH-th qualified data bit, the FSM SHALL go to DONE, or to PARITY if compiled in.
REQ-016 DONE lasts one cycle: it loads the shift register into q and sets q_vld the next cycle, then returns to IDLE; latency is last data bit edge -> q_vld high 2 cycles later.
REQ-017 A qualified si in DONE SHALL be ignored; a start bit is accepted only from IDLE.
REQ-018 q and q_vld SHALL hold stable while q_vld=1 and q_rdy=0.
REQ-019 A handshake (q_vld & q_rdy) without a simultaneous load SHALL clear q_vld the next cycle; q holds its value.
REQ-020 A load in DONE while q_vld=1 and q_rdy=0 SHALL drop the new word, keep q, and set ovr_err.
REQ-021 A load in DONE with q_vld=1 and q_rdy=1 in the same cycle SHALL replace q with the new word, keep q_vld=1, and not flag overrun.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL reset to 0 on every entry to SHIFT.
REQ-023 err_clr SHALL clear the sticky flags next cycle; a set event in the same cycle SHALL win over err_clr.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, counter=0, shift register=0, q=0, q_vld=0, ovr_err=0 and par_err=0, regardless of the clock.
REQ-025 Reset asserted mid-frame SHALL discard the partial frame; after release the block SHALL wait for a new start bit.
REQ-026 The first state change after release SHALL occur no earlier than the first rising clk edge with rst_n=1.

Configuration
REQ-027 Macro SIPO_FRAME_PARITY_EN: when defined, SHALL add the PARITY state, which consumes one qualified bit after the data bits.
REQ-028 With the macro defined, the block SHALL add output port par_err (1 bit, sticky), set when the data bits XOR the parity bit is not 0 (even parity).
REQ-029 With the macro defined, a parity-failing word SHALL still load per REQ-016..021, and latency SHALL be parity bit edge -> q_vld high 2 cycles later.
REQ-030 Without the macro, the design SHALL have no PARITY state, no par_err port, and the frame SHALL be 1 start bit plus WIDTH data bits.

Verification
REQ-031 WIDTH=4, q_rdy=1, si_vld=1 each cycle, si sequence 1,1,0,0,1 -> q=4'b1001 and q_vld high 2 cycles after the last bit, busy high for 5 cycles.
REQ-032 The same frame with si_vld=0 inserted between bits -> identical q=4'b1001, with the latency extended only by the gap cycles.
REQ-033 Two back-to-back frames 4'b1001 then 4'b0110 with q_rdy=0 -> q stays 4'b1001 and ovr_err=1; err_clr pulse -> ovr_err=0.
REQ-034 Second frame completes with q_rdy=1 in its DONE cycle -> q=4'b0110, q_vld stays 1, ovr_err=0.
REQ-035 rst_n pulsed low after 2 data bits -> all outputs 0 asynchronously; the next full frame 4'b1111 is received correctly.
REQ-036 With SIPO_FRAME_PARITY_EN defined, frame 1,1,0,1,1 then parity bit 0 -> par_err=1 and q=4'b1011; with parity bit 1 -> par_err=0.
